// File: rtl/freq_div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// freq_div_ctrl_pkg
// Shared types and constants for the runtime-programmable clock divider.
//   fdc_state_e       : controller state (STOP, RUN, PEND)
//   FDC_DEFAULT_CNT_W : default width of the half-period counter/config value
// Optional feature macro used by the top: FREQ_DIV_CTRL_TICK_CNT_EN
// ----------------------------------------------------------------------------
package freq_div_ctrl_pkg;

    localparam int FDC_DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fdc_state_e;

endpackage

// File: rtl/fdc_half_counter.sv
// ----------------------------------------------------------------------------
// fdc_half_counter
// Half-period counter for freq_div_ctrl. Counts 0..half_i-1 while enabled and
// flags the cycle in which the divided clock must toggle; the count wraps to 0
// on that same edge.
// Ports:
//   clk_in    in   system clock (rising edge)
//   reset_n   in   asynchronous active-low reset
//   enable_i  in   count while high
//   load_i    in   restart the count at 0 for a newly loaded half-period
//   clear_i   in   hold the count at 0 (stopped)
//   half_i    in   half-period in use, CNT_W bits
//   toggle_o  out  count has reached half_i-1 this cycle
// ----------------------------------------------------------------------------
module fdc_half_counter
    import freq_div_ctrl_pkg::*;
#(
    parameter int CNT_W = FDC_DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             toggle_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign toggle_o = enable_i && (count_q == (half_i - CNT_W'(1)));

    // Next count: clear/load dominate, otherwise advance and wrap on toggle.
    always_comb begin
        count_d = count_q;
        if (clear_i || load_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = toggle_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// ----------------------------------------------------------------------------
// freq_div_ctrl
// Runtime-programmable clock divider. Produces a 50%-duty registered clk_out
// and single-cycle rise/fall ticks. New half-periods arrive over a valid/ready
// port and are applied only at a falling toggle, so clk_out never shows a runt
// pulse. A half-period of 0 stops the output at the next falling toggle.
// Ports:
//   clk_in       in   system clock (rising edge)
//   reset_n      in   asynchronous active-low reset
//   cfg_valid    in   config request
//   cfg_ready    out  config can be accepted (low while one is pending)
//   cfg_half     in   requested half-period, 0 = stop
//   clk_out      out  divided clock
//   tick_rise    out  high in the first cycle clk_out reads 1
//   tick_fall    out  high in the first cycle clk_out reads 0 (not on stop)
//   running      out  state is RUN or PEND
//   active_half  out  half-period in use, 0 when stopped
//   tick_cnt     out  count of tick_rise pulses (only with
//                     FREQ_DIV_CTRL_TICK_CNT_EN defined)
// ----------------------------------------------------------------------------
module freq_div_ctrl
    import freq_div_ctrl_pkg::*;
#(
    parameter int          CNT_W        = FDC_DEFAULT_CNT_W,
    parameter int unsigned DEFAULT_HALF = 195
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             running,
    output logic [CNT_W-1:0] active_half
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
    ,
    output logic [15:0]      tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] RST_HALF  = CNT_W'(DEFAULT_HALF);
    localparam fdc_state_e       RST_STATE = (RST_HALF != '0) ? RUN : STOP;

    fdc_state_e       state_q, state_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             cnt_load;
    logic             toggle;
    logic             hs;

    assign cfg_ready   = (state_q != PEND);
    assign hs          = cfg_valid && cfg_ready;
    assign clk_out     = clk_q;
    assign tick_rise   = rise_q;
    assign tick_fall   = fall_q;
    assign running     = (state_q != STOP);
    assign active_half = active_q;

    fdc_half_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .enable_i (state_q != STOP),
        .load_i   (cnt_load),
        .clear_i  (state_q == STOP),
        .half_i   (active_q),
        .toggle_o (toggle)
    );

    // Controller: a pending value is only consumed on a falling toggle, and a
    // handshake landing on a falling toggle in RUN waits for the next one.
    // Falling into STOP raises no tick, since ticks stay low in STOP.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        pend_d   = pend_q;
        clk_d    = clk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        cnt_load = 1'b0;
        case (state_q)
            STOP: begin
                clk_d = 1'b0;
                if (hs && (cfg_half != '0)) begin
                    active_d = cfg_half;
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
            end
            RUN: begin
                if (toggle) begin
                    clk_d  = !clk_q;
                    rise_d = !clk_q;
                    fall_d = clk_q;
                end
                if (hs) begin
                    pend_d  = cfg_half;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (toggle && clk_q) begin
                    clk_d    = 1'b0;
                    cnt_load = 1'b1;
                    if (pend_q != '0) begin
                        active_d = pend_q;
                        fall_d   = 1'b1;
                        state_d  = RUN;
                    end else begin
                        active_d = '0;
                        state_d  = STOP;
                    end
                end else if (toggle) begin
                    clk_d  = 1'b1;
                    rise_d = 1'b1;
                end
            end
            default: begin
                state_d  = STOP;
                active_d = '0;
                clk_d    = 1'b0;
            end
        endcase
    end

    // State, config and output registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RST_STATE;
            active_q <= RST_HALF;
            pend_q   <= '0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
    logic [15:0] tick_cnt_q;

    // Rise-tick counter; any accepted config clears it, taking priority.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (hs) begin
            tick_cnt_q <= '0;
        end else if (rise_d) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_freq_div_ctrl
// Self-checking bench for freq_div_ctrl with DEFAULT_HALF = 3. Directed
// scenarios compare against timelines written out arithmetically; a random
// run compares every cycle against a level/countdown reference model.
// ----------------------------------------------------------------------------
module tb_freq_div_ctrl;

    localparam int CNT_W    = 16;
    localparam int DEF_HALF = 3;

    logic             clk_in    = 1'b0;
    logic             reset_n   = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_half  = '0;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick_rise;
    logic             tick_fall;
    logic             running;
    logic [CNT_W-1:0] active_half;
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
    logic [15:0]      tick_cnt;
`endif

    int nTests = 0;
    int nFail  = 0;

    // Reference model: current level, cycles left in it, pending request.
    bit mStopped;
    bit mLevel;
    int mHalf;
    int mLeft;
    bit mPendValid;
    int mPend;
    bit mRise;
    bit mFall;
    int mTickCnt;

    freq_div_ctrl #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_half    (cfg_half),
        .clk_out     (clk_out),
        .tick_rise   (tick_rise),
        .tick_fall   (tick_fall),
        .running     (running),
        .active_half (active_half)
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
        ,
        .tick_cnt    (tick_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic modelReset();
        mStopped   = (DEF_HALF == 0);
        mLevel     = 1'b0;
        mHalf      = DEF_HALF;
        mLeft      = DEF_HALF;
        mPendValid = 1'b0;
        mPend      = 0;
        mRise      = 1'b0;
        mFall      = 1'b0;
        mTickCnt   = 0;
    endtask

    task automatic modelStep(input bit hs, input int cfg);
        mRise = 1'b0;
        mFall = 1'b0;
        if (mStopped) begin
            if (hs && cfg != 0) begin
                mHalf    = cfg;
                mLeft    = cfg;
                mLevel   = 1'b0;
                mStopped = 1'b0;
            end
        end else begin
            if (mLeft == 1) begin
                if (mLevel && mPendValid) begin
                    mPendValid = 1'b0;
                    mLevel     = 1'b0;
                    if (mPend == 0) begin
                        mStopped = 1'b1;
                        mHalf    = 0;
                    end else begin
                        mHalf = mPend;
                        mLeft = mPend;
                        mFall = 1'b1;
                    end
                end else begin
                    mLevel = !mLevel;
                    mLeft  = mHalf;
                    mRise  = mLevel;
                    mFall  = !mLevel;
                end
            end else begin
                mLeft = mLeft - 1;
            end
            if (hs) begin
                mPendValid = 1'b1;
                mPend      = cfg;
            end
        end
        if (hs) mTickCnt = 0;
        else if (mRise) mTickCnt = (mTickCnt + 1) % 65536;
    endtask

    // One clk_in cycle: present inputs, step model on the edge, settle 1 ns.
    task automatic cycle(input logic v, input logic [CNT_W-1:0] h);
        bit hs;
        cfg_valid = v;
        cfg_half  = h;
        hs        = v && !mPendValid;
        @(posedge clk_in);
        modelStep(hs, int'(h));
        #1;
    endtask

    task automatic doReset();
        cfg_valid = 1'b0;
        cfg_half  = '0;
        reset_n   = 1'b0;
        @(posedge clk_in);
        #1;
        modelReset();
        @(posedge clk_in);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] exp3;
        doReset();
        nTests++;
        if ({clk_out, tick_rise, tick_fall, cfg_ready, running} !== 5'b00011) begin
            nFail++;
            $display("[TB] FAIL reset_flags got=%b exp=00011",
                     {clk_out, tick_rise, tick_fall, cfg_ready, running});
        end
        nTests++;
        if (active_half !== 16'(DEF_HALF)) begin
            nFail++;
            $display("[TB] FAIL reset_active got=%0d exp=%0d", active_half, DEF_HALF);
        end
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, '0);
            exp3 = {((k / 3) % 2) == 1, (k % 6) == 3, (k % 6) == 0};
            nTests++;
            if ({clk_out, tick_rise, tick_fall} !== exp3) begin
                nFail++;
                $display("[TB] FAIL reset_wave k=%0d got=%b exp=%b", k,
                         {clk_out, tick_rise, tick_fall}, exp3);
            end
        end
    endtask

    task automatic test_retune();
        logic [17:0] exp;
        doReset();
        for (int k = 1; k <= 20; k++) begin
            cycle(k == 4, 16'd5);
            exp[17] = (k < 6) ? (((k / 3) % 2) == 1) : ((((k - 6) / 5) % 2) == 1);
            exp[16] = !(k == 4 || k == 5);
            exp[15:0] = (k < 6) ? 16'd3 : 16'd5;
            nTests++;
            if ({clk_out, cfg_ready, active_half} !== exp) begin
                nFail++;
                $display("[TB] FAIL retune k=%0d clk/ready/half got=%b/%b/%0d exp=%b/%b/%0d",
                         k, clk_out, cfg_ready, active_half, exp[17], exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_stop_restart();
        logic [19:0] exp;
        doReset();
        for (int k = 1; k <= 20; k++) begin
            if (k <= 12) begin
                cycle(k == 2, 16'd0);
                exp[19] = (k < 6) ? (((k / 3) % 2) == 1) : 1'b0;
                exp[18] = (k == 3);
                exp[17] = 1'b0;
                exp[16] = (k < 6);
                exp[15:0] = (k < 6) ? 16'd3 : 16'd0;
            end else begin
                cycle(k == 13, 16'd2);
                exp[19] = (((k - 13) / 2) % 2) == 1;
                exp[18] = ((k - 13) % 4) == 2;
                exp[17] = (k > 13) && (((k - 13) % 4) == 0);
                exp[16] = 1'b1;
                exp[15:0] = 16'd2;
            end
            nTests++;
            if ({clk_out, tick_rise, tick_fall, running, active_half} !== exp) begin
                nFail++;
                $display("[TB] FAIL stop_restart k=%0d clk/rise/fall/run/half got=%b%b%b%b/%0d exp=%b/%0d",
                         k, clk_out, tick_rise, tick_fall, running, active_half,
                         exp[19:16], exp[15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        doReset();
        for (int k = 1; k <= 23; k++) begin
            cycle(k >= 6 && k <= 13, (k == 6) ? 16'd4 : 16'd2);
            if (k < 12) exp[17] = ((k / 3) % 2) == 1;
            else if (k < 20) exp[17] = (((k - 12) / 4) % 2) == 1;
            else exp[17] = (((k - 20) / 2) % 2) == 1;
            exp[16] = (k < 6) || (k == 12) || (k >= 20);
            exp[15:0] = (k < 12) ? 16'd3 : ((k < 20) ? 16'd4 : 16'd2);
            nTests++;
            if ({clk_out, cfg_ready, active_half} !== exp) begin
                nFail++;
                $display("[TB] FAIL back_to_back k=%0d clk/ready/half got=%b/%b/%0d exp=%b/%b/%0d",
                         k, clk_out, cfg_ready, active_half, exp[17], exp[16], exp[15:0]);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid_pend();
        doReset();
        cycle(1'b0, '0);
        cycle(1'b1, 16'd5);
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        nTests++;
        if ({clk_out, cfg_ready} !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL pend_before_reset clk/ready got=%b exp=10", {clk_out, cfg_ready});
        end
        #2;
        reset_n = 1'b0;
        #1;
        nTests++;
        if ({clk_out, tick_rise, tick_fall, cfg_ready, running, active_half} !== {5'b00011, 16'd3}) begin
            nFail++;
            $display("[TB] FAIL async_reset flags got=%b half=%0d exp=00011 half=3",
                     {clk_out, tick_rise, tick_fall, cfg_ready, running}, active_half);
        end
        @(posedge clk_in);
        #1;
        modelReset();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, '0);
            nTests++;
            if ({clk_out, active_half} !== {((k / 3) % 2) == 1, 16'd3}) begin
                nFail++;
                $display("[TB] FAIL after_pend_reset k=%0d clk=%b half=%0d exp clk=%0d half=3",
                         k, clk_out, active_half, (k / 3) % 2);
            end
        end
    endtask

    task automatic test_random();
        logic [20:0] exp;
        doReset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 5) == 0, 16'($urandom_range(0, 4)));
            exp = {mLevel, mRise, mFall, !mStopped, !mPendValid, 16'(mHalf)};
            nTests++;
            if ({clk_out, tick_rise, tick_fall, running, cfg_ready, active_half} !== exp) begin
                nFail++;
                $display("[TB] FAIL random i=%0d clk/rise/fall/run/ready/half got=%b/%0d exp=%b/%0d",
                         i, {clk_out, tick_rise, tick_fall, running, cfg_ready}, active_half,
                         exp[20:16], exp[15:0]);
            end
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
            nTests++;
            if (tick_cnt !== 16'(mTickCnt)) begin
                nFail++;
                $display("[TB] FAIL random_tick_cnt i=%0d got=%0d exp=%0d", i, tick_cnt, mTickCnt);
            end
`endif
        end
        cfg_valid = 1'b0;
    endtask

`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
    task automatic test_tick_cnt();
        int expCnt;
        doReset();
        for (int k = 1; k <= 31; k++) begin
            cycle(k == 1 || k == 31, 16'd1);
            if (k < 3 || k == 31) expCnt = 0;
            else if (k < 7) expCnt = 1;
            else expCnt = 1 + (k - 5) / 2;
            nTests++;
            if (tick_cnt !== 16'(expCnt)) begin
                nFail++;
                $display("[TB] FAIL tick_cnt k=%0d got=%0d exp=%0d", k, tick_cnt, expCnt);
            end
        end
        cfg_valid = 1'b0;
    endtask
`endif

    initial begin
        modelReset();
        test_reset();
        test_retune();
        test_stop_restart();
        test_back_to_back();
        test_reset_mid_pend();
`ifdef FREQ_DIV_CTRL_TICK_CNT_EN
        test_tick_cnt();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Runtime-programmable clock divider controller. It generates a 50 %-duty divided clock `clk_out` plus single-cycle edge ticks from `clk_in`. Its half-period can be reconfigured, or the output stopped, through a valid/ready config port. Every divisor change takes effect only at a full-period boundary, so `clk_out` never produces a runt pulse. It replaces fixed-ratio dividers wherever firmware or a mode FSM must retune a derived clock (e.g. 64 kHz audio/sample strobes from 25 MHz).

## Interface
- `CNT_W`, 16: width of half-period counter and config value.
- `DEFAULT_HALF`, 195: half-period loaded at reset, in `clk_in` cycles (25000/64/2). A value of 0 means the block resets into STOP.
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted; handshake occurs when `cfg_valid && cfg_ready`.
- `cfg_half`  in  CNT_W  requested half-period; 0 is a stop request.
- `clk_out`  out  1  divided clock, registered.
- `tick_rise`  out  1  one-cycle pulse, high in the same cycle `clk_out` first reads 1.
- `tick_fall`  out  1  one-cycle pulse, high in the same cycle `clk_out` first reads 0.
- `running`  out  1  state is RUN or PEND.
- `active_half`  out  CNT_W  half-period currently in use (0 when stopped).

## Operation
- **States:**
  - STOP: `clk_out` = 0, counter held at 0.
  - RUN: dividing, no pending config.
  - PEND: dividing, one accepted config waiting.
- **Counting:** the counter runs 0..`active_half`-1. When count == `active_half`-1, `clk_out` toggles and the count wraps to 0. Each level therefore lasts exactly `active_half` cycles, giving a period of 2×`active_half`. `active_half` = 1 gives `clk_in`/2.
- **STOP + handshake, `cfg_half` ≠ 0:** load `active_half`, go to RUN. Count = 0 and `clk_out` = 0 next cycle.
- **STOP + handshake, `cfg_half` = 0:** no effect; stay in STOP.
- **RUN + handshake:** latch `cfg_half` into `pend_half` and go to PEND. `cfg_ready` = 0 while in PEND.
- **Switch point:** the falling toggle (count == `active_half`-1 with `clk_out` = 1).
  - If `pend_half` ≠ 0: load it into `active_half`, count = 0, go to RUN.
  - If `pend_half` = 0: `clk_out` falls, go to STOP, `active_half` = 0.
- **Same-cycle handshake and falling toggle in RUN:** the value goes to PEND and is applied at the *next* falling toggle, not the current one.
- **Rising toggle:** never applies a pending config.
- **Reset (any time, including mid-period or in PEND):** asynchronously discard the pending config and return to reset values.

## Timing
- **Reset values:**
  - `clk_out` = 0, `tick_rise` = 0, `tick_fall` = 0, `cfg_ready` = 1, count = 0.
  - `active_half` = `DEFAULT_HALF`.
  - `running` = (`DEFAULT_HALF` ≠ 0); state RUN if `DEFAULT_HALF` ≠ 0, else STOP.
- **First rising edge after entering RUN:** `clk_out` reads 1 exactly `active_half` cycles later.
- **Config latency:** a handshake in PEND-eligible RUN takes effect within ≤ 2×`active_half` cycles.
- **Back-pressure:** `cfg_ready` deasserts the cycle after a RUN handshake. It reasserts the cycle after the switch.
- **Ticks:** never both high in one cycle; always low in STOP.

## Configuration
- `FREQ_DIV_CTRL_TICK_CNT_EN`:
  - **Defined:** adds output `tick_cnt` [15:0], counting `tick_rise` pulses. It resets to 0, wraps 0xFFFF→0, and clears on any accepted config.
  - **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- **Package `freq_div_ctrl_pkg`:** state enum `fdc_state_e` {STOP, RUN, PEND} and localparam `FDC_DEFAULT_CNT_W` = 16.
- **Sub-module `fdc_half_counter`:** counter plus toggle/wrap compare. Takes load/clear/enable and `active_half`; outputs `toggle`. The top holds the FSM, `pend_half` and the tick registers.

## Test plan
- **Reset with `DEFAULT_HALF`=3:** `clk_out` period 6 cycles, high 3 / low 3. `tick_rise` first at cycle 3 after reset release.
- **Retune in RUN:** half=3, send `cfg_half`=5 mid-high-phase. Current period completes at 3/3, then 5/5 with no runt pulse. `cfg_ready` is low only between handshake+1 and switch+1.
- **Stop request:** `cfg_half`=0 in RUN. `clk_out` falls at the next falling toggle, then stays 0. `running` = 0, `active_half` = 0, no further ticks. A subsequent `cfg_half`=2 restarts with the first rise 2 cycles later.
- **Simultaneous events:** handshake in the exact cycle of a falling toggle. The new value is applied one full period later. A second `cfg_valid` held during PEND is not accepted until `cfg_ready` returns.
- **Reset mid-PEND:** assert `reset_n`=0 asynchronously. All outputs immediately take reset values and the pending value is lost.
- **With `FREQ_DIV_CTRL_TICK_CNT_EN`, half=1:** `tick_cnt` increments every 2 cycles and wraps 0xFFFF→0. Any config handshake clears it to 0.
